// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Brief   : Shared ALU types: opcode tags, flag bit positions, result-stage
//           occupancy states.
// Rev     : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_OR   = 4'd1,
        OP_NOR  = 4'd2,
        OP_XOR  = 4'd3,
        OP_ADD  = 4'd4,
        OP_SUB  = 4'd5,
        OP_NAND = 4'd6,
        OP_XNOR = 4'd7
    } alu_op_t;

    // Bit positions inside the 4-bit {C,P,N,Z} flag word
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_P = 2;
    localparam int FLAG_C = 3;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_flag_gen.sv
`default_nettype none
// ============================================================================
// Module  : alu_flag_gen
// Brief   : Combinational {C,P,N,Z} flag generator for an ALU result word.
// Rev     : 1.0  initial release
// ============================================================================
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] i_result,
    input  logic             i_carry,
    output logic [3:0]       o_flags
);

    always_comb begin
        o_flags         = '0;
        o_flags[FLAG_Z] = (i_result == '0);
        o_flags[FLAG_N] = i_result[WIDTH-1];
        // Parity is 1 when the word holds an odd number of ones
        o_flags[FLAG_P] = ^i_result;
        o_flags[FLAG_C] = i_carry;
    end

endmodule
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module  : alu_result_stage
// Brief   : Two-entry in-order result buffer between ALU units and writeback,
//           attaching flags at push and counting accepted results.
// Rev     : 1.0  initial release
// ============================================================================
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [3:0]       in_op,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_op,
    output logic [3:0]       out_flags,
    output logic [CNT_W-1:0] op_count
);

    occ_state_t       r_state;
    occ_state_t       w_state_nxt;

    logic [WIDTH-1:0] r_head_result;
    logic [3:0]       r_head_op;
    logic [3:0]       r_head_flags;
    logic [WIDTH-1:0] r_skid_result;
    logic [3:0]       r_skid_op;
    logic [3:0]       r_skid_flags;
    logic [CNT_W-1:0] r_op_count;

    logic [3:0]       w_in_flags;
    logic             w_push;
    logic             w_pop;
    logic             w_load_head_new;
    logic             w_load_head_skid;
    logic             w_load_skid;

    alu_flag_gen #(
        .WIDTH    (WIDTH)
    ) u_flag_gen (
        .i_result (in_result),
        .i_carry  (in_carry),
        .o_flags  (w_in_flags)
    );

    // Readiness depends only on registered occupancy (and reset), never on out_ready
    assign in_ready  = !rst && (r_state != ST_FULL);
    assign out_valid = (r_state != ST_EMPTY);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_head_new  = 1'b0;
        w_load_head_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_state_nxt     = ST_ONE;
                    w_load_head_new = 1'b1;
                end
            end
            ST_ONE: begin
                case ({w_push, w_pop})
                    2'b10: begin
                        w_state_nxt = ST_FULL;
                        w_load_skid = 1'b1;
                    end
                    2'b01: w_state_nxt = ST_EMPTY;
                    2'b11: w_load_head_new = 1'b1;
                    default: ;
                endcase
            end
            ST_FULL: begin
                if (w_pop) begin
                    w_state_nxt      = ST_ONE;
                    w_load_head_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Head only changes when a new entry takes its place, so outputs hold when empty
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_EMPTY;
            r_head_result <= '0;
            r_head_op     <= '0;
            r_head_flags  <= '0;
            r_skid_result <= '0;
            r_skid_op     <= '0;
            r_skid_flags  <= '0;
            r_op_count    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_head_new) begin
                r_head_result <= in_result;
                r_head_op     <= in_op;
                r_head_flags  <= w_in_flags;
            end else if (w_load_head_skid) begin
                r_head_result <= r_skid_result;
                r_head_op     <= r_skid_op;
                r_head_flags  <= r_skid_flags;
            end
            if (w_load_skid) begin
                r_skid_result <= in_result;
                r_skid_op     <= in_op;
                r_skid_flags  <= w_in_flags;
            end
            if (w_push) begin
                r_op_count <= r_op_count + CNT_W'(1);
            end
        end
    end

    assign out_result = r_head_result;
    assign out_op     = r_head_op;
    assign out_flags  = r_head_flags;
    assign op_count   = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_result_stage
// Brief   : Self-checking bench for alu_result_stage with an in-order scoreboard.
// Rev     : 1.0  initial release
// ============================================================================
module tb_alu_result_stage;
    import alu_pkg::*;

    localparam int WIDTH = 16;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_result = '0;
    logic [3:0]       in_op = '0;
    logic             in_carry = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_op;
    logic [3:0]       out_flags;
    logic [CNT_W-1:0] op_count;

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [23:0]      sb[$];
    logic [CNT_W-1:0] exp_cnt = '0;

    alu_result_stage #(
        .WIDTH      (WIDTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_op      (in_op),
        .in_carry   (in_carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_op     (out_op),
        .out_flags  (out_flags),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] model_flags(input logic [WIDTH-1:0] r, input logic c);
        int ones = 0;
        for (int b = 0; b < WIDTH; b++) ones += int'(r[b]);
        return {c, logic'(ones % 2), r[WIDTH-1], logic'(r == 16'h0000)};
    endfunction

    // Handshakes are evaluated mid-cycle; they take effect at the next rising edge
    always @(negedge clk) begin
        logic [23:0] exp;
        if (rst) begin
            sb.delete();
            exp_cnt = '0;
        end else begin
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_pop: got result=%h op=%h flags=%b, expected no output", out_result, out_op, out_flags);
                end else begin
                    exp = sb.pop_front();
                    if ({out_result, out_op, out_flags} !== exp) begin
                        n_fail++;
                        $display("FAIL sb_entry: got result=%h op=%h flags=%b, expected result=%h op=%h flags=%b",
                                 out_result, out_op, out_flags, exp[23:8], exp[7:4], exp[3:0]);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back({in_result, in_op, model_flags(in_result, in_carry)});
                exp_cnt = exp_cnt + 16'd1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int guard = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && guard < 20) begin
            tick();
            guard++;
        end
        n_checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d pending, out_valid=%b, expected 0 pending", name, sb.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_result = 16'hABCD; out_ready = 1'b1;
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || op_count !== 16'h0000 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got out_valid=%b op_count=%h in_ready=%b, expected 0 0000 0", out_valid, op_count, in_ready);
        end
        n_checks++;
        if (out_result !== 16'h0000 || out_op !== 4'h0 || out_flags !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_data: got result=%h op=%h flags=%b, expected zeros", out_result, out_op, out_flags);
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_single_push();
        in_valid = 1'b1; in_result = 16'h0000; in_op = OP_NOR; in_carry = 1'b0; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_flags !== 4'b0001 || op_count !== 16'd1 || out_op !== OP_NOR) begin
            n_fail++;
            $display("FAIL single_push: got valid=%b flags=%b count=%h op=%h, expected 1 0001 0001 %h",
                     out_valid, out_flags, op_count, out_op, OP_NOR);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || out_result !== 16'h0000) begin
            n_fail++;
            $display("FAIL single_pop: got valid=%b result=%h, expected 0 0000", out_valid, out_result);
        end
    endtask

    task automatic test_fill();
        logic [CNT_W-1:0] base = op_count;
        out_ready = 1'b0;
        in_valid = 1'b1; in_result = 16'h8001; in_op = OP_AND; in_carry = 1'b0;
        tick();
        n_checks++;
        if (out_flags !== 4'b0010 || out_result !== 16'h8001) begin
            n_fail++;
            $display("FAIL fill_first: got result=%h flags=%b, expected 8001 0010", out_result, out_flags);
        end
        in_result = 16'h7FFF; in_op = OP_OR;
        tick();
        n_checks++;
        if (in_ready !== 1'b0 || out_result !== 16'h8001) begin
            n_fail++;
            $display("FAIL fill_full: got in_ready=%b head=%h, expected 0 8001", in_ready, out_result);
        end
        in_result = 16'h1234; in_op = OP_XOR;
        tick();
        tick();
        n_checks++;
        if (op_count !== base + 16'd2 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_blocked: got count=%h in_ready=%b, expected %h 0", op_count, in_ready, base + 16'd2);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_result !== 16'h7FFF || out_flags !== 4'b0100 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_second: got result=%h flags=%b valid=%b, expected 7fff 0100 1", out_result, out_flags, out_valid);
        end
        drain("fill");
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid = 1'b1; in_result = 16'h0100; in_op = OP_ADD; in_carry = 1'b1;
        tick();
        for (int i = 1; i <= 10; i++) begin
            in_result = 16'h0100 + 16'(i); in_carry = logic'(i % 2); out_ready = 1'b1;
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_result !== 16'h0100 + 16'(i)) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: got valid=%b in_ready=%b head=%h, expected 1 1 %h",
                         i, out_valid, in_ready, out_result, 16'h0100 + 16'(i));
            end
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_empty: got out_valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            in_valid  = logic'($urandom_range(0, 1));
            out_ready = logic'($urandom_range(0, 3) != 0);
            in_result = 16'($urandom);
            in_op     = 4'($urandom_range(0, 7));
            in_carry  = logic'($urandom_range(0, 1));
            tick();
            n_checks++;
            if (op_count !== exp_cnt || out_valid !== (sb.size() != 0)) begin
                n_fail++;
                $display("FAIL rand_cycle%0d: got count=%h valid=%b, expected %h %b", i, op_count, out_valid, exp_cnt, sb.size() != 0);
            end
        end
        drain("rand");
    endtask

    task automatic test_wrap();
        int guard = 0;
        in_valid = 1'b1; out_ready = 1'b1; in_result = 16'h5A5A; in_op = OP_SUB; in_carry = 1'b0;
        while (exp_cnt != 16'hFFFF && guard < 70000) begin
            tick();
            guard++;
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (op_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL wrap_preload: got count=%h, expected ffff", op_count);
        end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (op_count !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_rollover: got count=%h, expected 0000", op_count);
        end
        drain("wrap");
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_result = 16'hDEAD; in_op = OP_AND;
        tick();
        in_result = 16'hBEEF;
        tick();
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_full: got in_ready=%b, expected 0", in_ready);
        end
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || op_count !== 16'h0000) begin
            n_fail++;
            $display("FAIL rstmid_flush: got out_valid=%b count=%h, expected 0 0000", out_valid, op_count);
        end
        rst = 1'b0;
        tick();
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_stale: got out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill();
        test_back_to_back();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter: WIDTH, 16, datapath width of result, matching the 16-bit bitwise logic units.
REQ-002 Parameter: CNT_W, 16, width of accepted-result counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream result valid.
REQ-006 in_ready  output  1  stage can accept a result this cycle.
REQ-007 in_result  input  WIDTH  result word from the selected logic/arith unit (e.g. bitwise NOR output).
REQ-008 in_op  input  4  opcode tag of the producing operation (alu_op_t).
REQ-009 in_carry  input  1  carry/borrow from producing unit; 0 for bitwise ops.
REQ-010 out_valid  output  1  head entry valid.
REQ-011 out_ready  input  1  downstream accepts head entry.
REQ-012 out_result  output  WIDTH  head result word.
REQ-013 out_op  output  4  head opcode tag.
REQ-014 out_flags  output  4  head flags {C,P,N,Z}.
REQ-015 op_count  output  CNT_W  number of results accepted since reset, modulo 2^CNT_W.

Function
REQ-016 Stage SHALL be a 2-entry in-order buffer between ALU units and writeback; occupancy state EMPTY(0), ONE(1), FULL(2).
REQ-017 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-018 in_ready SHALL equal (state != FULL), derived from registered state only; no combinational path from out_ready.
REQ-019 out_valid SHALL equal (state != EMPTY); out_result/out_op/out_flags SHALL reflect head entry and be stable while out_valid && !out_ready.
REQ-020 Transitions: EMPTY+push->ONE; ONE+push only->FULL; ONE+pop only->EMPTY; ONE+push+pop->ONE (new entry becomes head next cycle); FULL+pop->ONE; otherwise hold.
REQ-021 Latency: result pushed in cycle N SHALL appear at output in cycle N+1 when buffer empty; no same-cycle bypass.
REQ-022 Flags SHALL be computed from in_result at push: Z = (in_result == 0); N = in_result[WIDTH-1]; P = XOR-reduction of in_result (1 = odd ones); C = in_carry.
REQ-023 in_valid while FULL SHALL NOT change buffer contents or op_count; upstream holds data.
REQ-024 op_count SHALL increment by 1 per push and wrap from 2^CNT_W-1 to 0.
REQ-025 Order SHALL be preserved; no entry dropped or duplicated under any push/pop combination.
REQ-026 When out_valid is low, data outputs SHALL hold last values (don't-care for consumers).

Reset
REQ-027 While rst high: state EMPTY, in_ready 0, out_valid 0, out_result 0, out_op 0, out_flags 0, op_count 0; in_valid/out_ready ignored.
REQ-028 First cycle after rst deasserts: in_ready 1, out_valid 0.
REQ-029 rst asserted mid-operation SHALL discard all buffered entries at next edge.

Structure
REQ-030 Shared package alu_pkg SHALL hold WIDTH default, alu_op_t (4-bit opcode enum incl. OP_AND, OP_OR, OP_NOR, OP_XOR, OP_ADD, OP_SUB), and flag bit index constants FLAG_Z=0, FLAG_N=1, FLAG_P=2, FLAG_C=3.
REQ-031 Flag computation SHALL be one combinational sub-module alu_flag_gen (in: result, carry; out: 4-bit flags); buffer/state logic stays in alu_result_stage.

Verification
REQ-032 Reset: hold rst 2 cycles with in_valid=1 -> out_valid 0, op_count 0, in_ready 0; after release in_ready 1.
REQ-033 Single push: in_result=0x0000, op=OP_NOR, carry=0, out_ready=1 -> next cycle out_valid 1, out_flags=4'b0001, op_count 1.
REQ-034 Fill/backpressure: out_ready=0, push 0x8001 then 0x7FFF -> flags 4'b0010 then 4'b0100, in_ready 0; third in_valid with 0x1234 not accepted, op_count stays 2; release out_ready -> 0x8001, 0x7FFF emitted in order.
REQ-035 Simultaneous push+pop in ONE state for 10 cycles, incrementing data -> out_valid continuous, order exact, state remains ONE.
REQ-036 Counter wrap: preload via 65535 pushes (or force) -> next push gives op_count 0x0000.
REQ-037 Reset mid-operation while FULL -> next cycle out_valid 0, op_count 0, stale entries never emitted.
